// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals: pipeline writeback,
// multi-cycle result handshake, regfile write port and decode hazard query.
interface regfile_wr_arbiter_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          pend1;
  logic          pend2;
  logic          stall_o;
  logic [CW-1:0] fifo_cnt;

  modport master (
    output a_we, a_addr, a_data, b_valid, b_addr, b_data, raddr1, raddr2,
    input  b_ready, rf_we, rf_waddr, rf_wdata, pend1, pend2, stall_o, fifo_cnt
  );

  modport slave (
    input  a_we, a_addr, a_data, b_valid, b_addr, b_data, raddr1, raddr2,
    output b_ready, rf_we, rf_waddr, rf_wdata, pend1, pend2, stall_o, fifo_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port: pipeline writeback always wins, multi-cycle
// results queue in a small FIFO with WAW kill, hazard reporting and starvation stall.
module regfile_wr_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic          w_a_win;
  logic          w_not_empty;
  logic          w_head_live;
  logic          w_head_wr;
  logic          w_pop;
  logic          w_b_ready;
  logic          w_enq;
  logic          w_enq_live;
  logic [SW-1:0] w_starve_nxt;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic          w_pend1;
  logic          w_pend2;

  assign w_a_win     = bus.a_we && (bus.a_addr != '0);
  assign w_not_empty = (r_count != '0);
  assign w_head_live = w_not_empty && r_live[r_rd_ptr];
  assign w_head_wr   = w_head_live && !w_a_win;
  // A killed head leaves even while A owns the port; a live one only when A is idle.
  assign w_pop       = w_not_empty && (!r_live[r_rd_ptr] || !w_a_win);
  assign w_b_ready   = (r_count < CW'(DEPTH));
  assign w_enq       = bus.b_valid && w_b_ready && (bus.b_addr != '0);
  assign w_enq_live  = !(w_a_win && (bus.b_addr == bus.a_addr));

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_head_wr)
      w_starve_nxt = '0;
    else if (w_head_live && w_a_win && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + 1'b1;
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (w_a_win) begin
      w_we    = 1'b1;
      w_waddr = bus.a_addr;
      w_wdata = bus.a_data;
    end else if (w_head_live) begin
      w_we    = 1'b1;
      w_waddr = r_addr[r_rd_ptr];
      w_wdata = r_data[r_rd_ptr];
    end
  end

  // The entry draining this cycle still reports pending; bypass covers it.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_addr[i] == bus.raddr1) && (bus.raddr1 != '0)) w_pend1 = 1'b1;
      if (r_live[i] && (r_addr[i] == bus.raddr2) && (bus.raddr2 != '0)) w_pend2 = 1'b1;
    end
  end

  assign bus.rf_we    = rst && w_we;
  assign bus.rf_waddr = rst ? w_waddr : '0;
  assign bus.rf_wdata = rst ? w_wdata : '0;
  assign bus.b_ready  = rst && w_b_ready;
  assign bus.pend1    = rst && w_pend1;
  assign bus.pend2    = rst && w_pend2;
  assign bus.stall_o  = r_stall;
  assign bus.fifo_cnt = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_a_win) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_addr[i] == bus.a_addr) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end
      if (w_enq) begin
        r_live[r_wr_ptr] <= w_enq_live;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      r_count  <= r_count + CW'(w_enq) - CW'(w_pop);
      r_starve <= w_starve_nxt;
      if (w_head_wr)
        r_stall <= 1'b0;
      else if (w_starve_nxt == SW'(STARVE_LIMIT))
        r_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && rst) begin
      r_addr[r_wr_ptr] <= bus.b_addr;
      r_data[r_wr_ptr] <= bus.b_data;
    end
  end
endmodule
